// File: rtl/ins_fetcher_pkg.sv
// Shared widths, fetch FSM encodings and the instruction-queue entry layout
// for the RV32I fetch stage.
package ins_fetcher_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int INS_WIDTH  = 32;

   typedef enum logic [1:0] {
      IF_IDLE    = 2'd0,
      IF_WAIT    = 2'd1,
      IF_DISCARD = 2'd2
   } if_state_e;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [INS_WIDTH-1:0]  ins;
      logic [ADDR_WIDTH-1:0] pred_pc;
   } iq_entry_t;

   localparam int IQ_ENTRY_W = $bits(iq_entry_t);

   function automatic logic [ADDR_WIDTH-1:0] next_seq_pc(input logic [ADDR_WIDTH-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/ins_fetcher_queue.sv
// Parametric synchronous FIFO with push/pop/clear; head outputs come straight
// from the storage registers so the consumer sees no extra combinational depth.
module ins_queue #(
   parameter int DEPTH  = 4,
   parameter int IDX_W  = 2,
   parameter int DATA_W = 96
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   input  logic              clear,
   output logic [IDX_W:0]    count,
   output logic              head_valid,
   output logic [DATA_W-1:0] head_data
);

   localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [IDX_W-1:0]  r_head;
   logic [IDX_W-1:0]  r_tail;
   logic [IDX_W:0]    r_count;

   logic w_pop;
   logic w_push;

   // A push into a full queue is only legal when the head leaves in the same cycle.
   assign w_pop  = pop && (r_count != '0);
   assign w_push = push && ((r_count != FULL_COUNT) || w_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (rdy) begin
         if (clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) begin
               r_mem[r_tail] <= push_data;
               r_tail        <= r_tail + 1'b1;
            end
            if (w_pop) begin
               r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   assign count      = r_count;
   assign head_valid = (r_count != '0);
   assign head_data  = r_mem[r_head];

endmodule

// File: rtl/ins_fetcher.sv
// Instruction-fetch stage: one outstanding I-cache request, branch-predictor
// next-PC selection, and a small instruction queue drained by dispatch.
module ins_fetcher
   import ins_fetcher_pkg::*;
#(
   parameter int          IQ_DEPTH = 4,
   parameter int          IQ_IDX_W = 2,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   output logic                  icache_req,
   output logic [ADDR_WIDTH-1:0] icache_addr,
   input  logic                  icache_valid,
   input  logic [INS_WIDTH-1:0]  icache_ins,
   output logic [ADDR_WIDTH-1:0] pc_cur,
   output logic [INS_WIDTH-1:0]  ins_cur,
   input  logic                  pred_enable,
   input  logic [ADDR_WIDTH-1:0] pred_pc,
   output logic                  iq_valid,
   output logic [ADDR_WIDTH-1:0] iq_pc,
   output logic [INS_WIDTH-1:0]  iq_ins,
   output logic [ADDR_WIDTH-1:0] iq_pred_pc,
   input  logic                  iq_pop,
   input  logic                  rob_clear,
   input  logic [ADDR_WIDTH-1:0] rob_target_pc
);

   localparam logic [IQ_IDX_W:0] FULL_COUNT = (IQ_IDX_W+1)'(IQ_DEPTH);

   if_state_e             r_state;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic                  r_req;
   logic [ADDR_WIDTH-1:0] r_addr;

   logic [ADDR_WIDTH-1:0] w_npc;
   logic                  w_push;
   logic                  w_has_space;
   logic [IQ_IDX_W:0]     w_count;
   logic [IQ_ENTRY_W-1:0] w_head_bits;
   iq_entry_t             w_head;
   iq_entry_t             w_push_entry;

   assign w_npc        = pred_enable ? pred_pc : next_seq_pc(r_addr);
   assign w_push       = (r_state == IF_WAIT) && icache_valid && !rob_clear;
   assign w_has_space  = (w_count < FULL_COUNT);
   assign w_push_entry = '{pc: r_addr, ins: icache_ins, pred_pc: w_npc};

   // A redirect always wins; an in-flight response the cache cannot abort is
   // swallowed in DISCARD so it never lands in the queue under a stale PC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IF_IDLE;
         r_pc    <= RESET_PC;
         r_req   <= 1'b0;
         r_addr  <= '0;
      end else if (rdy) begin
         case (r_state)
            IF_IDLE: begin
               if (rob_clear) begin
                  r_pc <= rob_target_pc;
               end else if (w_has_space) begin
                  r_req   <= 1'b1;
                  r_addr  <= r_pc;
                  r_state <= IF_WAIT;
               end
            end
            IF_WAIT: begin
               if (rob_clear) begin
                  r_pc    <= rob_target_pc;
                  r_req   <= 1'b0;
                  r_state <= icache_valid ? IF_IDLE : IF_DISCARD;
               end else if (icache_valid) begin
                  r_pc    <= w_npc;
                  r_req   <= 1'b0;
                  r_state <= IF_IDLE;
               end
            end
            IF_DISCARD: begin
               r_req <= 1'b0;
               if (rob_clear) begin
                  r_pc <= rob_target_pc;
               end
               if (icache_valid) begin
                  r_state <= IF_IDLE;
               end
            end
            default: begin
               r_req   <= 1'b0;
               r_state <= IF_IDLE;
            end
         endcase
      end
   end

   ins_queue #(
      .DEPTH  (IQ_DEPTH),
      .IDX_W  (IQ_IDX_W),
      .DATA_W (IQ_ENTRY_W)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .push       (w_push),
      .push_data  (w_push_entry),
      .pop        (iq_pop),
      .clear      (rob_clear),
      .count      (w_count),
      .head_valid (iq_valid),
      .head_data  (w_head_bits)
   );

   assign w_head      = w_head_bits;
   assign iq_pc       = w_head.pc;
   assign iq_ins      = w_head.ins;
   assign iq_pred_pc  = w_head.pred_pc;

   assign icache_req  = r_req;
   assign icache_addr = r_addr;
   assign pc_cur      = r_addr;
   assign ins_cur     = icache_ins;

endmodule
